// File: rtl/lv_fault_fsm_if.sv
// Register-file / datapath side bundle of the LV fault state machine.
// Master drives error sources and control bits; slave is lv_fault_fsm.
interface lv_fault_fsm_if #(
  parameter int ERR_NUM    = 16,
  parameter int DBNC_W     = 4,
  parameter int BIST_TMO_W = 12
);
  localparam int ID_W = (ERR_NUM > 1) ? $clog2(ERR_NUM) : 1;

  logic                  i_pwr_on;
  logic                  i_io_fsenb_n;
  logic [ERR_NUM-1:0]    i_err_raw;
  logic [ERR_NUM-1:0]    i_err_mask;
  logic [ERR_NUM-1:0]    i_err_fatal;
  logic [ERR_NUM-1:0]    i_err_clr;
  logic [DBNC_W-1:0]     i_dbnc_th;
  logic                  i_nml_en;
  logic                  i_cfg_en;
  logic                  i_rst_en;
  logic                  i_bist_en;
  logic                  i_bist_done;
  logic [BIST_TMO_W-1:0] i_bist_tmo_th;

  logic [ERR_NUM-1:0]    o_err_sticky;
  logic                  o_first_vld;
  logic [ID_W-1:0]       o_first_id;
  logic                  o_bist_tmo;
  logic [2:0]            o_cur_st;
  logic                  o_pwm_en;
  logic                  o_fsc_en;
  logic                  o_bist_en;
  logic                  o_intb_n;

  modport master (
    output i_pwr_on, i_io_fsenb_n, i_err_raw, i_err_mask, i_err_fatal, i_err_clr,
           i_dbnc_th, i_nml_en, i_cfg_en, i_rst_en, i_bist_en, i_bist_done, i_bist_tmo_th,
    input  o_err_sticky, o_first_vld, o_first_id, o_bist_tmo, o_cur_st,
           o_pwm_en, o_fsc_en, o_bist_en, o_intb_n
  );

  modport slave (
    input  i_pwr_on, i_io_fsenb_n, i_err_raw, i_err_mask, i_err_fatal, i_err_clr,
           i_dbnc_th, i_nml_en, i_cfg_en, i_rst_en, i_bist_en, i_bist_done, i_bist_tmo_th,
    output o_err_sticky, o_first_vld, o_first_id, o_bist_tmo, o_cur_st,
           o_pwm_en, o_fsc_en, o_bist_en, o_intb_n
  );
endinterface

// File: rtl/lv_fault_fsm.sv
// LV operating-mode FSM with per-source error qualification, sticky latch and BIST watchdog.
// Optional debounce counters are built only when LV_FAULT_DBNC_EN is defined.
module lv_fault_fsm #(
  parameter int ERR_NUM    = 16,
  parameter int DBNC_W     = 4,
  parameter int BIST_TMO_W = 12
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  lv_fault_fsm_if.slave  bus
);
  localparam int ID_W = (ERR_NUM > 1) ? $clog2(ERR_NUM) : 1;

  typedef enum logic [2:0] {
    ST_PWR_DWN  = 3'd0,
    ST_WAIT     = 3'd1,
    ST_NML      = 3'd2,
    ST_FAILSAFE = 3'd3,
    ST_FAULT    = 3'd4,
    ST_CFG      = 3'd5,
    ST_BIST     = 3'd6,
    ST_RST      = 3'd7
  } state_t;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [ERR_NUM-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int k = ERR_NUM - 1; k >= 0; k--) begin
      if (v[k]) idx = ID_W'(k);
    end
    return idx;
  endfunction

  state_t                r_state;
  state_t                w_nxt;
  logic [ERR_NUM-1:0]    r_sticky;
  logic                  r_first_vld;
  logic [ID_W-1:0]       r_first_id;
  logic [BIST_TMO_W-1:0] r_bist_cnt;
  logic                  r_bist_tmo;
  logic                  r_pwm_en;
  logic                  r_fsc_en;
  logic                  r_bist_en;
  logic                  r_intb_n;

  logic [ERR_NUM-1:0]    w_act;
  logic [ERR_NUM-1:0]    w_qual;
  logic [ERR_NUM-1:0]    w_sticky_nxt;
  logic                  w_err_any;
  logic                  w_err_hard;
  logic                  w_rst_entry;
  logic                  w_bist_entry;
  logic                  w_bist_tmo;
  logic [BIST_TMO_W-1:0] w_bist_cnt_nxt;
  logic                  w_bist_tmo_nxt;

  assign w_act = bus.i_err_raw & ~bus.i_err_mask;

`ifdef LV_FAULT_DBNC_EN
  logic [DBNC_W-1:0] r_dbnc_cnt [ERR_NUM];

  // Counter saturates so a long-held source stays qualified for any threshold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < ERR_NUM; k++) r_dbnc_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < ERR_NUM; k++) begin
        if (!w_act[k])
          r_dbnc_cnt[k] <= '0;
        else if (r_dbnc_cnt[k] != {DBNC_W{1'b1}})
          r_dbnc_cnt[k] <= r_dbnc_cnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    w_qual = '0;
    for (int k = 0; k < ERR_NUM; k++)
      w_qual[k] = w_act[k] & (r_dbnc_cnt[k] >= bus.i_dbnc_th);
  end
`else
  assign w_qual = w_act;
`endif

  assign w_err_any  = |r_sticky;
  assign w_err_hard = |(r_sticky & bus.i_err_fatal);

  // Next-state logic; power loss overrides everything.
  always_comb begin
    w_nxt = r_state;
    if (!bus.i_pwr_on) begin
      w_nxt = ST_PWR_DWN;
    end else begin
      case (r_state)
        ST_PWR_DWN: w_nxt = ST_WAIT;
        ST_WAIT: begin
          if (bus.i_nml_en && !w_err_any)
            w_nxt = bus.i_io_fsenb_n ? ST_NML : ST_FAILSAFE;
        end
        ST_NML: begin
          if (bus.i_cfg_en)            w_nxt = ST_CFG;
          else if (w_err_any)          w_nxt = ST_FAULT;
          else if (!bus.i_io_fsenb_n)  w_nxt = ST_FAILSAFE;
        end
        ST_FAILSAFE: begin
          if (w_err_hard)                             w_nxt = ST_FAULT;
          else if (bus.i_io_fsenb_n && !w_err_any)    w_nxt = ST_NML;
        end
        ST_FAULT: begin
          if (bus.i_cfg_en)                           w_nxt = ST_CFG;
          else if (!w_err_hard && !bus.i_io_fsenb_n)  w_nxt = ST_FAILSAFE;
          else if (!w_err_any && bus.i_io_fsenb_n)    w_nxt = ST_NML;
        end
        ST_CFG: begin
          if (bus.i_rst_en)                           w_nxt = ST_RST;
          else if (bus.i_bist_en && !w_err_hard)      w_nxt = ST_BIST;
          else if (!bus.i_cfg_en && w_err_any)        w_nxt = ST_FAULT;
          else if (!bus.i_cfg_en)
            w_nxt = bus.i_io_fsenb_n ? ST_NML : ST_FAILSAFE;
        end
        ST_BIST: begin
          if (bus.i_bist_done || !bus.i_bist_en || w_bist_tmo) w_nxt = ST_CFG;
        end
        ST_RST: begin
          if (!bus.i_rst_en) w_nxt = ST_WAIT;
        end
        default: w_nxt = ST_PWR_DWN;
      endcase
    end
  end

  assign w_rst_entry  = (w_nxt == ST_RST)  && (r_state != ST_RST);
  assign w_bist_entry = (w_nxt == ST_BIST) && (r_state != ST_BIST);
  assign w_bist_tmo   = (r_state == ST_BIST) && (r_bist_cnt == bus.i_bist_tmo_th);

  assign w_sticky_nxt = w_rst_entry ? '0 : ((r_sticky & ~bus.i_err_clr) | w_qual);

  always_comb begin
    w_bist_cnt_nxt = r_bist_cnt;
    if (w_bist_entry)
      w_bist_cnt_nxt = '0;
    else if (r_state == ST_BIST)
      w_bist_cnt_nxt = r_bist_cnt + 1'b1;
  end

  // Flag rises on the edge the watchdog count lands on the threshold.
  assign w_bist_tmo_nxt = w_rst_entry ? 1'b0 :
                          (r_bist_tmo | ((w_nxt == ST_BIST) && (w_bist_cnt_nxt == bus.i_bist_tmo_th)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sticky    <= '0;
      r_first_vld <= 1'b0;
      r_first_id  <= '0;
    end else begin
      r_sticky <= w_sticky_nxt;
      if (w_rst_entry) begin
        r_first_vld <= 1'b0;
        r_first_id  <= '0;
      end else if (r_sticky == '0 && w_sticky_nxt != '0) begin
        r_first_vld <= 1'b1;
        r_first_id  <= lowest_idx(w_sticky_nxt);
      end else if (w_sticky_nxt == '0) begin
        r_first_vld <= 1'b0;
      end
    end
  end

  // State register and outputs registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_PWR_DWN;
      r_bist_cnt <= '0;
      r_bist_tmo <= 1'b0;
      r_pwm_en   <= 1'b0;
      r_fsc_en   <= 1'b0;
      r_bist_en  <= 1'b0;
      r_intb_n   <= 1'b1;
    end else begin
      r_state    <= w_nxt;
      r_bist_cnt <= w_bist_cnt_nxt;
      r_bist_tmo <= w_bist_tmo_nxt;
      r_pwm_en   <= (w_nxt == ST_NML) ||
                    ((w_nxt == ST_FAULT) && !w_err_hard && r_pwm_en);
      r_fsc_en   <= (w_nxt == ST_FAILSAFE) ||
                    ((w_nxt == ST_FAULT) && !w_err_hard && r_fsc_en);
      r_bist_en  <= (w_nxt == ST_BIST);
      r_intb_n   <= !((w_nxt == ST_PWR_DWN) || (w_nxt == ST_WAIT) ||
                      (w_nxt == ST_FAULT)   || (w_nxt == ST_RST)  ||
                      ((w_nxt == ST_CFG) && w_err_any) || w_bist_tmo_nxt);
    end
  end

  assign bus.o_err_sticky = r_sticky;
  assign bus.o_first_vld  = r_first_vld;
  assign bus.o_first_id   = r_first_id;
  assign bus.o_bist_tmo   = r_bist_tmo;
  assign bus.o_cur_st     = r_state;
  assign bus.o_pwm_en     = r_pwm_en;
  assign bus.o_fsc_en     = r_fsc_en;
  assign bus.o_bist_en    = r_bist_en;
  assign bus.o_intb_n     = r_intb_n;
endmodule

// File: tb/tb_lv_fault_fsm.sv
// Directed bench for lv_fault_fsm: power-up, qualification, fault classes, BIST watchdog, power loss.
module tb_lv_fault_fsm;
  localparam int ERR_NUM    = 16;
  localparam int DBNC_W     = 4;
  localparam int BIST_TMO_W = 12;
`ifdef LV_FAULT_DBNC_EN
  localparam int DLY = 3;
`else
  localparam int DLY = 0;
`endif

  logic i_clk = 1'b0;
  logic i_rst_n;
  int   checks = 0;
  int   failures = 0;

  lv_fault_fsm_if #(.ERR_NUM(ERR_NUM), .DBNC_W(DBNC_W), .BIST_TMO_W(BIST_TMO_W)) bus ();

  lv_fault_fsm #(.ERR_NUM(ERR_NUM), .DBNC_W(DBNC_W), .BIST_TMO_W(BIST_TMO_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    i_rst_n              = 1'b0;
    bus.i_pwr_on         = 1'b0;
    bus.i_io_fsenb_n     = 1'b1;
    bus.i_err_raw        = '0;
    bus.i_err_mask       = '0;
    bus.i_err_fatal      = 16'h0004;
    bus.i_err_clr        = '0;
    bus.i_dbnc_th        = 4'd3;
    bus.i_nml_en         = 1'b1;
    bus.i_cfg_en         = 1'b0;
    bus.i_rst_en         = 1'b0;
    bus.i_bist_en        = 1'b0;
    bus.i_bist_done      = 1'b0;
    bus.i_bist_tmo_th    = 12'd10;
    step(2);
    chk("rst_st",     32'(bus.o_cur_st), 32'd0);
    chk("rst_intb",   32'(bus.o_intb_n), 32'd1);
    chk("rst_pwm",    32'(bus.o_pwm_en), 32'd0);
    chk("rst_sticky", 32'(bus.o_err_sticky), 32'd0);
    chk("rst_tmo",    32'(bus.o_bist_tmo), 32'd0);

    // Power-up sequence
    i_rst_n = 1'b1;
    bus.i_pwr_on = 1'b1;
    step(1);
    chk("pu_wait_st",   32'(bus.o_cur_st), 32'd1);
    chk("pu_wait_intb", 32'(bus.o_intb_n), 32'd0);
    step(1);
    chk("pu_nml_st",   32'(bus.o_cur_st), 32'd2);
    chk("pu_nml_pwm",  32'(bus.o_pwm_en), 32'd1);
    chk("pu_nml_intb", 32'(bus.o_intb_n), 32'd1);

`ifdef LV_FAULT_DBNC_EN
    bus.i_err_raw = 16'h0020;
    step(3);
    bus.i_err_raw = '0;
    step(2);
    chk("glitch_sticky", 32'(bus.o_err_sticky), 32'd0);
    chk("glitch_st",     32'(bus.o_cur_st), 32'd2);
`endif

    // Soft source 5 qualifies
    bus.i_err_raw = 16'h0020;
    step(DLY + 1);
    chk("dbnc_sticky", 32'(bus.o_err_sticky), 32'h0020);
    chk("dbnc_st_pre", 32'(bus.o_cur_st), 32'd2);
    chk("dbnc_fvld",   32'(bus.o_first_vld), 32'd1);
    chk("dbnc_fid",    32'(bus.o_first_id), 32'd5);
    step(1);
    chk("dbnc_fault_st", 32'(bus.o_cur_st), 32'd4);
    chk("dbnc_pwm_hold", 32'(bus.o_pwm_en), 32'd1);
    chk("dbnc_intb",     32'(bus.o_intb_n), 32'd0);

    // Set/clear collision: set wins
    bus.i_err_clr = 16'h0020;
    step(1);
    bus.i_err_clr = '0;
    chk("coll_sticky", 32'(bus.o_err_sticky), 32'h0020);
    bus.i_err_raw = '0;
    step(1);
    bus.i_err_clr = 16'h0020;
    step(1);
    bus.i_err_clr = '0;
    chk("clr_sticky", 32'(bus.o_err_sticky), 32'd0);
    chk("clr_fvld",   32'(bus.o_first_vld), 32'd0);
    chk("clr_st",     32'(bus.o_cur_st), 32'd4);
    step(1);
    chk("back_nml_st",  32'(bus.o_cur_st), 32'd2);
    chk("back_nml_pwm", 32'(bus.o_pwm_en), 32'd1);

    // Fatal source in FAILSAFE
    bus.i_io_fsenb_n = 1'b0;
    step(1);
    chk("fs_st",  32'(bus.o_cur_st), 32'd3);
    chk("fs_fsc", 32'(bus.o_fsc_en), 32'd1);
    chk("fs_pwm", 32'(bus.o_pwm_en), 32'd0);
    bus.i_err_raw = 16'h0004;
    step(DLY + 1);
    chk("fatal_sticky", 32'(bus.o_err_sticky), 32'h0004);
    chk("fatal_st_pre", 32'(bus.o_cur_st), 32'd3);
    step(1);
    chk("fatal_st",   32'(bus.o_cur_st), 32'd4);
    chk("fatal_fsc",  32'(bus.o_fsc_en), 32'd0);
    chk("fatal_pwm",  32'(bus.o_pwm_en), 32'd0);
    chk("fatal_fid",  32'(bus.o_first_id), 32'd2);
    chk("fatal_intb", 32'(bus.o_intb_n), 32'd0);
    bus.i_err_raw = '0;
    bus.i_err_clr = 16'h0004;
    step(1);
    bus.i_err_clr = '0;
    chk("fatal_clr", 32'(bus.o_err_sticky), 32'd0);
    chk("fatal_st2", 32'(bus.o_cur_st), 32'd4);
    bus.i_io_fsenb_n = 1'b1;
    bus.i_cfg_en = 1'b1;
    step(1);
    chk("cfg_st",   32'(bus.o_cur_st), 32'd5);
    chk("cfg_intb", 32'(bus.o_intb_n), 32'd1);

    // BIST watchdog, threshold 10
    bus.i_bist_en = 1'b1;
    step(1);
    chk("bist_st", 32'(bus.o_cur_st), 32'd6);
    chk("bist_en", 32'(bus.o_bist_en), 32'd1);
    step(9);
    chk("bist_tmo_pre", 32'(bus.o_bist_tmo), 32'd0);
    step(1);
    chk("bist_tmo",    32'(bus.o_bist_tmo), 32'd1);
    chk("bist_tmo_st", 32'(bus.o_cur_st), 32'd6);
    step(1);
    chk("tmo_cfg_st",   32'(bus.o_cur_st), 32'd5);
    chk("tmo_cfg_intb", 32'(bus.o_intb_n), 32'd0);
    chk("tmo_bist_en",  32'(bus.o_bist_en), 32'd0);
    bus.i_bist_en = 1'b0;
    step(1);
    chk("tmo_hold", 32'(bus.o_bist_tmo), 32'd1);
    bus.i_rst_en = 1'b1;
    step(1);
    chk("rst_st_in",  32'(bus.o_cur_st), 32'd7);
    chk("rst_tmo_cl", 32'(bus.o_bist_tmo), 32'd0);
    bus.i_rst_en = 1'b0;
    bus.i_cfg_en = 1'b0;
    step(1);
    chk("rst_wait", 32'(bus.o_cur_st), 32'd1);
    step(1);
    chk("rst_nml", 32'(bus.o_cur_st), 32'd2);

    // Masked source never latches
    bus.i_err_mask = 16'h0200;
    bus.i_err_raw  = 16'h0200;
    step(DLY + 2);
    chk("mask_sticky", 32'(bus.o_err_sticky), 32'd0);
    chk("mask_st",     32'(bus.o_cur_st), 32'd2);
    bus.i_err_raw  = '0;
    bus.i_err_mask = '0;

    // Power loss during BIST
    bus.i_cfg_en = 1'b1;
    step(1);
    bus.i_bist_en     = 1'b1;
    bus.i_bist_tmo_th = 12'd100;
    step(1);
    chk("pl_bist_st", 32'(bus.o_cur_st), 32'd6);
    bus.i_pwr_on = 1'b0;
    step(1);
    chk("pl_st",      32'(bus.o_cur_st), 32'd0);
    chk("pl_bist_en", 32'(bus.o_bist_en), 32'd0);
    bus.i_pwr_on  = 1'b1;
    bus.i_bist_en = 1'b0;
    bus.i_cfg_en  = 1'b0;
    step(2);
    chk("pl_nml", 32'(bus.o_cur_st), 32'd2);

    // Asynchronous reset mid-operation
    bus.i_err_raw = 16'h0080;
    step(DLY + 1);
    chk("ar_sticky_pre", 32'(bus.o_err_sticky), 32'h0080);
    #2 i_rst_n = 1'b0;
    #1;
    chk("ar_st",     32'(bus.o_cur_st), 32'd0);
    chk("ar_sticky", 32'(bus.o_err_sticky), 32'd0);
    chk("ar_fvld",   32'(bus.o_first_vld), 32'd0);
    chk("ar_pwm",    32'(bus.o_pwm_en), 32'd0);
    chk("ar_intb",   32'(bus.o_intb_n), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lv_fault_fsm.md
# lv_fault_fsm

Parametrised successor of the LV control state machine. It aggregates `ERR_NUM` error sources through per-source mask, debounce, sticky latch and fatal/soft classification. It runs the LV operating-mode FSM, including a BIST watchdog, and drives the PWM/failsafe enables and the interrupt pin. It sits between the register file (error status, control bits) and the PWM/failsafe datapath in `lv_top`.

## Interface
Parameters:
- `ERR_NUM`, 16: number of error sources (1..32).
- `DBNC_W`, 4: width of the debounce threshold and the per-source counters.
- `BIST_TMO_W`, 12: width of the BIST watchdog counter.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_pwr_on` in 1: supply good.
- `i_io_fsenb_n` in 1: failsafe pin, active-low.
- `i_err_raw` in `ERR_NUM`: raw error sources.
- `i_err_mask` in `ERR_NUM`: 1 = source ignored.
- `i_err_fatal` in `ERR_NUM`: 1 = fatal class, 0 = soft class.
- `i_err_clr` in `ERR_NUM`: one-cycle clear pulses, one per sticky bit.
- `i_dbnc_th` in `DBNC_W`: debounce threshold T.
- `i_nml_en` in 1: register control bit; permits leaving WAIT.
- `i_cfg_en` in 1: register control bit; request CFG.
- `i_rst_en` in 1: register control bit; request RST.
- `i_bist_en` in 1: register control bit; request BIST.
- `i_bist_done` in 1: BIST finished.
- `i_bist_tmo_th` in `BIST_TMO_W`: BIST timeout in cycles.
- `o_err_sticky` out `ERR_NUM`: latched qualified errors.
- `o_first_vld` out 1: first-fault capture valid.
- `o_first_id` out `$clog2(ERR_NUM)`: index of the first fault.
- `o_bist_tmo` out 1: sticky BIST timeout flag.
- `o_cur_st` out 3: current FSM state.
- `o_pwm_en` out 1: PWM enable.
- `o_fsc_en` out 1: failsafe-control enable.
- `o_bist_en` out 1: BIST enable.
- `o_intb_n` out 1: interrupt pin, active-low.

## Operation
- State encoding: PWR_DWN=0, WAIT=1, NML=2, FAILSAFE=3, FAULT=4, CFG=5, BIST=6, RST=7. All 8 codes are legal.
- Per source k:
  - `act[k] = i_err_raw[k] & ~i_err_mask[k]`.
  - The counter clears when `act[k]` is low and increments (saturating) while it is high.
  - `qual[k]` is asserted when `act[k]` has been high on T+1 consecutive edges.
  - `qual[k]` sets `o_err_sticky[k]`. `i_err_clr[k]` clears the bit; if set and clear coincide, set wins.
- Derived terms:
  - `err_any = |o_err_sticky`.
  - `err_hard = |(o_err_sticky & i_err_fatal)`.
- First-fault capture:
  - On the edge where sticky goes from all-zero to non-zero, capture the lowest newly set index and set `o_first_vld`.
  - `o_first_vld` clears when all sticky bits are zero.
- Transitions: `~i_pwr_on` forces PWR_DWN from every state and has the highest priority. The remaining conditions are listed in priority order.
  - PWR_DWN: `i_pwr_on` → WAIT.
  - WAIT: `i_nml_en & ~err_any` → FAILSAFE if `~i_io_fsenb_n`, else NML.
  - NML: `i_cfg_en` → CFG; `err_any` → FAULT; `~i_io_fsenb_n` → FAILSAFE.
  - FAILSAFE: `err_hard` → FAULT; `i_io_fsenb_n & ~err_any` → NML.
  - FAULT: `i_cfg_en` → CFG; `~err_hard & ~i_io_fsenb_n` → FAILSAFE; `~err_any & i_io_fsenb_n` → NML.
  - CFG: `i_rst_en` → RST; `i_bist_en & ~err_hard` → BIST; `~i_cfg_en & err_any` → FAULT; `~i_cfg_en` → FAILSAFE or NML, selected by `i_io_fsenb_n`.
  - BIST: `i_bist_done | ~i_bist_en | timeout` → CFG.
    - The watchdog counter clears on BIST entry and counts each cycle spent in BIST.
    - Timeout occurs when the count equals `i_bist_tmo_th`. Timeout sets `o_bist_tmo`.
    - `i_err_clr` does not clear `o_bist_tmo`; entering RST does.
  - RST: `~i_rst_en` → WAIT. Entering RST clears all sticky bits and the first-fault capture.
- Outputs are registered from the next state:
  - `o_pwm_en` = (nxt==NML), or hold its value when nxt==FAULT & `~err_hard`.
  - `o_fsc_en` = (nxt==FAILSAFE), or hold its value when nxt==FAULT & `~err_hard`.
  - `o_bist_en` = (nxt==BIST).
  - `o_intb_n` = 0 when nxt ∈ {PWR_DWN, WAIT, FAULT, RST}, or nxt==CFG & `err_any`, or `o_bist_tmo`.

## Timing
- Reset values:
  - State = PWR_DWN.
  - `o_cur_st` = 0.
  - All counters, `o_err_sticky`, `o_first_*`, `o_bist_tmo`, `o_pwm_en`, `o_fsc_en` and `o_bist_en` = 0.
  - `o_intb_n` = 1.
- Error latency: `act` is first sampled high at edge E0.
  - Sticky sets at edge E0+T.
  - State and outputs react at edge E0+T+1.
- A glitch shorter than T+1 edges never sets sticky.
- The counter saturates at all-ones; T = all-ones is legal.
- The BIST timeout fires on the edge where the count reaches the threshold. `o_cur_st` reads CFG on the following edge.
- Reset asserted mid-operation returns all outputs to their reset values asynchronously.

## Configuration
- `LV_FAULT_DBNC_EN` defined: debounce counters are present as described above.
- `LV_FAULT_DBNC_EN` undefined:
  - Counters are removed and `i_dbnc_th` is ignored.
  - `qual = act`, so sticky sets at E0 (identical to T=0).

## Test plan
- Power-up: `i_pwr_on`=1, `i_nml_en`=1, `i_io_fsenb_n`=1, no errors → PWR_DWN, WAIT, NML on successive edges; `o_pwm_en`=1 and `o_intb_n`=1 when `o_cur_st`=2.
- Debounce: T=3, soft source 5 high for 3 cycles → sticky stays 0. Held high for 4 cycles → `o_err_sticky[5]`=1 at E0+3, FAULT at E0+4, `o_pwm_en` held at 1, `o_intb_n`=0, `o_first_id`=5.
- Fatal in FAILSAFE: fatal source 2 qualifies → FAULT; `o_fsc_en`=0 and `o_pwm_en`=0.
- Set/clear collision: `i_err_clr[5]` pulsed while source 5 is still qualified → sticky remains 1. Clear after the source drops → sticky 0, `o_first_vld`=0, FSM returns to NML.
- BIST watchdog: CFG → BIST with `i_bist_tmo_th`=10 and no done → `o_bist_tmo`=1 after 10 BIST cycles, state CFG, `o_intb_n`=0. Entering RST clears the flag.
- Power loss: `i_pwr_on`=0 while in BIST → PWR_DWN on the next edge; `o_bist_en`=0.
